// File: rtl/lsu_writeback.sv
// Load/store and write-back stage: one memory operation at a time over a req/ack
// handshake, with store lane steering, load extraction and access/timeout errors.
module lsu_writeback #(
   parameter int unsigned MEM_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        op_valid,
   output logic        op_ready,
   input  logic        op_load,
   input  logic [2:0]  op_funct3,
   input  logic [31:0] op_addr,
   input  logic [31:0] op_wdata,
   input  logic [4:0]  op_rd,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic [2:0]  rf_we,
   output logic [4:0]  rf_addr,
   output logic [31:0] rf_data,
   output logic        done,
   output logic        err_access,
   output logic        err_timeout
);

   typedef enum logic [1:0] {IDLE, REQ, WB} state_t;

   typedef struct packed {
      logic        op_ready;
      logic        mem_req;
      logic        mem_we;
      logic [31:0] mem_addr;
      logic [3:0]  mem_be;
      logic [31:0] mem_wdata;
      logic [2:0]  rf_we;
      logic [4:0]  rf_addr;
      logic [31:0] rf_data;
      logic        done;
      logic        err_access;
      logic        err_timeout;
   } out_t;

   localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

   state_t      state_q, state_d;
   out_t        o_q, o_d;
   logic        ld_q, ld_d;
   logic [2:0]  f3_q, f3_d;
   logic [1:0]  a_q, a_d;
   logic [4:0]  rd_q, rd_d;
   logic [7:0]  cnt_q, cnt_d;

   logic        illegal;
   logic [3:0]  st_be;
   logic [31:0] st_wdata;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] ld_value;

   // Decode of the incoming operation (only meaningful in IDLE).
   always_comb begin
      illegal = (op_funct3 == 3'b011) || (op_funct3[2:1] == 2'b11)
             || (op_funct3[2] && !op_load)
             || (op_funct3[1:0] == 2'b01 && op_addr[0])
             || (op_funct3 == 3'b010 && op_addr[1:0] != 2'b00);
      unique case (op_funct3[1:0])
         2'b00:   begin st_be = 4'b0001 << op_addr[1:0]; st_wdata = {4{op_wdata[7:0]}};  end
         2'b01:   begin st_be = op_addr[1] ? 4'b1100 : 4'b0011; st_wdata = {2{op_wdata[15:0]}}; end
         default: begin st_be = 4'b1111; st_wdata = op_wdata; end
      endcase
   end

   // Load alignment from the latched offset and width.
   always_comb begin
      ld_byte = mem_rdata[{a_q, 3'b000} +: 8];
      ld_half = mem_rdata[{a_q[1], 4'b0000} +: 16];
      unique case (f3_q)
         3'b000:  ld_value = {{24{ld_byte[7]}}, ld_byte};
         3'b100:  ld_value = {24'b0, ld_byte};
         3'b001:  ld_value = {{16{ld_half[15]}}, ld_half};
         3'b101:  ld_value = {16'b0, ld_half};
         default: ld_value = mem_rdata;
      endcase
   end

   always_comb begin
      // NOTE: every signal gets a default first so no path through the case infers a latch.
      state_d          = state_q;
      o_d              = o_q;
      o_d.done         = 1'b0;
      o_d.err_access   = 1'b0;
      o_d.err_timeout  = 1'b0;
      o_d.rf_we        = 3'b000;
      ld_d             = ld_q;
      f3_d             = f3_q;
      a_d              = a_q;
      rd_d             = rd_q;
      cnt_d            = cnt_q;

      unique case (state_q)
         IDLE: begin
            if (op_valid && o_q.op_ready) begin
               ld_d = op_load;
               f3_d = op_funct3;
               a_d  = op_addr[1:0];
               rd_d = op_rd;
               if (illegal) begin
                  o_d.err_access = 1'b1;
               end else begin
                  state_d         = REQ;
                  cnt_d           = 8'd0;
                  o_d.op_ready    = 1'b0;
                  o_d.mem_req     = 1'b1;
                  o_d.mem_we      = !op_load;
                  o_d.mem_addr    = {op_addr[31:2], 2'b00};
                  o_d.mem_be      = op_load ? 4'b1111 : st_be;
                  o_d.mem_wdata   = st_wdata;
               end
            end
         end
         REQ: begin
            if (mem_ack) begin
               o_d.mem_req = 1'b0;
               o_d.done    = 1'b1;
               if (ld_q) begin
                  state_d     = WB;
                  o_d.rf_we   = {2'b00, rd_q != 5'd0};
                  o_d.rf_addr = rd_q;
                  o_d.rf_data = ld_value;
               end else begin
                  state_d      = IDLE;
                  o_d.op_ready = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 8'd1;
               // Abort on the edge that would start cycle MEM_TIMEOUT+1 of the request.
               if (cnt_q == TIMEOUT_LAST) begin
                  state_d         = IDLE;
                  o_d.mem_req     = 1'b0;
                  o_d.err_timeout = 1'b1;
                  o_d.op_ready    = 1'b1;
               end
            end
         end
         WB: begin
            state_d      = IDLE;
            o_d.op_ready = 1'b1;
         end
         default: begin
            state_d      = IDLE;
            o_d.op_ready = 1'b1;
            o_d.mem_req  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         o_q         <= '0;
         o_q.op_ready <= 1'b1;
         ld_q        <= 1'b0;
         f3_q        <= 3'b000;
         a_q         <= 2'b00;
         rd_q        <= 5'd0;
         cnt_q       <= 8'd0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state_q <= state_d;
         o_q     <= o_d;
         ld_q    <= ld_d;
         f3_q    <= f3_d;
         a_q     <= a_d;
         rd_q    <= rd_d;
         cnt_q   <= cnt_d;
      end
   end

   assign op_ready    = o_q.op_ready;
   assign mem_req     = o_q.mem_req;
   assign mem_we      = o_q.mem_we;
   assign mem_addr    = o_q.mem_addr;
   assign mem_be      = o_q.mem_be;
   assign mem_wdata   = o_q.mem_wdata;
   assign rf_we       = o_q.rf_we;
   assign rf_addr     = o_q.rf_addr;
   assign rf_data     = o_q.rf_data;
   assign done        = o_q.done;
   assign err_access  = o_q.err_access;
   assign err_timeout = o_q.err_timeout;

endmodule

// File: tb/tb_lsu_writeback.sv
// Directed bench for lsu_writeback: table of single operations plus hand-written
// timeout and mid-transaction reset sequences.
module tb_lsu_writeback;

   logic        clk = 1'b0;
   logic        reset_n = 1'b1;
   logic        op_valid = 1'b0;
   logic        op_ready;
   logic        op_load = 1'b0;
   logic [2:0]  op_funct3 = 3'b000;
   logic [31:0] op_addr = '0;
   logic [31:0] op_wdata = '0;
   logic [4:0]  op_rd = '0;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        mem_ack = 1'b0;
   logic [31:0] mem_rdata = 32'hDEAD_0000;
   logic [2:0]  rf_we;
   logic [4:0]  rf_addr;
   logic [31:0] rf_data;
   logic        done;
   logic        err_access;
   logic        err_timeout;

   int n_tests = 0;
   int n_fail  = 0;

   lsu_writeback #(.MEM_TIMEOUT(4)) dut (
      .clk(clk), .reset_n(reset_n),
      .op_valid(op_valid), .op_ready(op_ready), .op_load(op_load),
      .op_funct3(op_funct3), .op_addr(op_addr), .op_wdata(op_wdata), .op_rd(op_rd),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
      .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .rf_we(rf_we), .rf_addr(rf_addr), .rf_data(rf_data), .done(done),
      .err_access(err_access), .err_timeout(err_timeout)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic        load;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [4:0]  rd;
      logic [31:0] rdata;
      int          wait_n;
      logic        exp_err;
      logic        exp_we;
      logic [31:0] exp_data;
      logic [3:0]  exp_be;
      logic [31:0] exp_wdata;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic load, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [4:0] rd);
      op_valid  = 1'b1;
      op_load   = load;
      op_funct3 = f3;
      op_addr   = addr;
      op_wdata  = wdata;
      op_rd     = rd;
      step();
      op_valid  = 1'b0;
   endtask

   task automatic run_vec(input int i, input vec_t v);
      string p;
      logic [31:0] exp_addr;
      p = $sformatf("v%0d", i);
      exp_addr = v.addr & 32'hFFFF_FFFC;
      issue(v.load, v.f3, v.addr, v.wdata, v.rd);
      if (v.exp_err) begin
         check({p, " err_access"}, 32'(err_access), 32'd1);
         check({p, " mem_req(err)"}, 32'(mem_req), 32'd0);
         check({p, " op_ready(err)"}, 32'(op_ready), 32'd1);
         step();
         check({p, " err_access clear"}, 32'(err_access), 32'd0);
         check({p, " mem_req after err"}, 32'(mem_req), 32'd0);
         check({p, " op_ready after err"}, 32'(op_ready), 32'd1);
         return;
      end
      check({p, " mem_req"}, 32'(mem_req), 32'd1);
      check({p, " mem_we"}, 32'(mem_we), 32'(!v.load));
      check({p, " op_ready busy"}, 32'(op_ready), 32'd0);
      for (int w = 0; w <= v.wait_n; w++) begin
         check({p, " mem_addr"}, mem_addr, exp_addr);
         check({p, " mem_be"}, 32'(mem_be), 32'(v.exp_be));
         if (!v.load) check({p, " mem_wdata"}, mem_wdata, v.exp_wdata);
         if (w < v.wait_n) begin
            step();
            check({p, " mem_req held"}, 32'(mem_req), 32'd1);
            check({p, " done early"}, 32'(done), 32'd0);
         end
      end
      mem_ack   = 1'b1;
      mem_rdata = v.rdata;
      step();
      mem_ack   = 1'b0;
      mem_rdata = 32'hDEAD_0000;
      check({p, " done"}, 32'(done), 32'd1);
      check({p, " mem_req dropped"}, 32'(mem_req), 32'd0);
      if (v.load) begin
         check({p, " rf_we"}, 32'(rf_we), 32'(v.exp_we));
         check({p, " rf_addr"}, 32'(rf_addr), 32'(v.rd));
         check({p, " rf_data"}, rf_data, v.exp_data);
         check({p, " op_ready in WB"}, 32'(op_ready), 32'd0);
      end else begin
         check({p, " rf_we store"}, 32'(rf_we), 32'd0);
         check({p, " op_ready after store"}, 32'(op_ready), 32'd1);
      end
      step();
      check({p, " done pulse"}, 32'(done), 32'd0);
      check({p, " rf_we pulse"}, 32'(rf_we), 32'd0);
      check({p, " op_ready idle"}, 32'(op_ready), 32'd1);
   endtask

   vec_t vecs[16];

   initial begin
      int req_cycles;
      bit seen_we;

      //          load f3      addr          wdata          rd     rdata         wt err we exp_data       be       exp_wdata
      vecs[0]  = '{1'b1, 3'b000, 32'h0000_0103, 32'h0,         5'd5,  32'h80FF_1234, 0, 0, 1, 32'hFFFF_FF80, 4'b1111, 32'h0};
      vecs[1]  = '{1'b1, 3'b101, 32'h0000_0202, 32'h0,         5'd7,  32'hBEEF_0000, 0, 0, 1, 32'h0000_BEEF, 4'b1111, 32'h0};
      vecs[2]  = '{1'b1, 3'b001, 32'h0000_0202, 32'h0,         5'd7,  32'hBEEF_0000, 1, 0, 1, 32'hFFFF_BEEF, 4'b1111, 32'h0};
      vecs[3]  = '{1'b0, 3'b000, 32'h0000_0011, 32'h1234_56AB, 5'd0,  32'h0,         3, 0, 0, 32'h0,         4'b0010, 32'hABAB_ABAB};
      vecs[4]  = '{1'b0, 3'b001, 32'h0000_0022, 32'h0000_CAFE, 5'd0,  32'h0,         1, 0, 0, 32'h0,         4'b1100, 32'hCAFE_CAFE};
      vecs[5]  = '{1'b0, 3'b001, 32'h0000_0020, 32'h1234_8765, 5'd0,  32'h0,         0, 0, 0, 32'h0,         4'b0011, 32'h8765_8765};
      vecs[6]  = '{1'b0, 3'b010, 32'h0000_0040, 32'hDEAD_BEEF, 5'd0,  32'h0,         0, 0, 0, 32'h0,         4'b1111, 32'hDEAD_BEEF};
      vecs[7]  = '{1'b1, 3'b010, 32'h0000_0006, 32'h0,         5'd4,  32'h0,         0, 1, 0, 32'h0,         4'b0000, 32'h0};
      vecs[8]  = '{1'b1, 3'b011, 32'h0000_0008, 32'h0,         5'd4,  32'h0,         0, 1, 0, 32'h0,         4'b0000, 32'h0};
      vecs[9]  = '{1'b1, 3'b010, 32'h0000_0080, 32'h0,         5'd0,  32'h1234_5678, 0, 0, 0, 32'h1234_5678, 4'b1111, 32'h0};
      vecs[10] = '{1'b1, 3'b100, 32'h0000_0101, 32'h0,         5'd3,  32'h0000_9C00, 0, 0, 1, 32'h0000_009C, 4'b1111, 32'h0};
      vecs[11] = '{1'b1, 3'b000, 32'h0000_0102, 32'h0,         5'd3,  32'h007F_0000, 2, 0, 1, 32'h0000_007F, 4'b1111, 32'h0};
      vecs[12] = '{1'b0, 3'b100, 32'h0000_0010, 32'h0000_0011, 5'd0,  32'h0,         0, 1, 0, 32'h0,         4'b0000, 32'h0};
      vecs[13] = '{1'b1, 3'b001, 32'h0000_0201, 32'h0,         5'd2,  32'h0,         0, 1, 0, 32'h0,         4'b0000, 32'h0};
      vecs[14] = '{1'b1, 3'b010, 32'h0000_0300, 32'h0,         5'd31, 32'hA5A5_5A5A, 3, 0, 1, 32'hA5A5_5A5A, 4'b1111, 32'h0};
      vecs[15] = '{1'b1, 3'b111, 32'h0000_0000, 32'h0,         5'd1,  32'h0,         0, 1, 0, 32'h0,         4'b0000, 32'h0};

      #2 reset_n = 1'b0;
      #9;
      check("reset op_ready", 32'(op_ready), 32'd1);
      check("reset mem_req", 32'(mem_req), 32'd0);
      check("reset mem_be", 32'(mem_be), 32'd0);
      check("reset rf_we", 32'(rf_we), 32'd0);
      check("reset done", 32'(done), 32'd0);
      check("reset errs", 32'({err_access, err_timeout}), 32'd0);
      reset_n = 1'b1;
      step();

      for (int i = 0; i < 16; i++) run_vec(i, vecs[i]);

      // Timeout: load with no ack keeps mem_req up for exactly 4 cycles.
      issue(1'b1, 3'b010, 32'h0000_0050, 32'h0, 5'd9);
      req_cycles = 0;
      seen_we = 1'b0;
      for (int c = 0; c < 20 && mem_req; c++) begin
         req_cycles++;
         if (rf_we != 3'd0 || done) seen_we = 1'b1;
         check("timeout no err early", 32'(err_timeout), 32'd0);
         step();
      end
      check("timeout mem_req cycles", 32'(req_cycles), 32'd4);
      check("timeout err pulse", 32'(err_timeout), 32'd1);
      check("timeout rf_we", 32'(rf_we), 32'd0);
      check("timeout done", 32'(done), 32'd0);
      check("timeout no write seen", 32'(seen_we), 32'd0);
      check("timeout op_ready", 32'(op_ready), 32'd1);
      step();
      check("timeout err clear", 32'(err_timeout), 32'd0);

      // Reset mid-request, then a stray ack after release.
      issue(1'b1, 3'b010, 32'h0000_0060, 32'h0, 5'd6);
      check("rst seq mem_req up", 32'(mem_req), 32'd1);
      step();
      reset_n = 1'b0;
      #1;
      check("rst async mem_req", 32'(mem_req), 32'd0);
      check("rst async op_ready", 32'(op_ready), 32'd1);
      #2 reset_n = 1'b1;
      step();
      mem_ack   = 1'b1;
      mem_rdata = 32'h1111_2222;
      step();
      mem_ack   = 1'b0;
      check("stray ack done", 32'(done), 32'd0);
      check("stray ack rf_we", 32'(rf_we), 32'd0);
      check("stray ack mem_req", 32'(mem_req), 32'd0);
      step();
      check("stray ack idle", 32'(op_ready), 32'd1);

      // A normal load still works after the aborted transaction.
      run_vec(99, vecs[0]);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/lsu_writeback.md
# lsu_writeback

Load/store and write-back stage between the execute stage and the register file. Accepts one memory operation at a time and runs a req/ack handshake with data memory. For loads, it aligns and sign/zero-extends the returned data and issues a single full-word register-file write (`rf_we`=1). It also builds byte enables and lane-replicated write data for stores, and reports misaligned/illegal accesses and memory timeouts.

## Interface
- `MEM_TIMEOUT`, default 255: REQ-state cycles without `mem_ack` before abort; range 1..255.

- `clk` in 1: single clock; all state updates on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `op_valid` in 1: operation request from execute.
- `op_ready` out 1: high only in IDLE; accept when `op_valid && op_ready`.
- `op_load` in 1: 1 = load, 0 = store.
- `op_funct3` in 3: 000 b, 001 h, 010 w, 100 bu, 101 hu (bu/hu are loads only).
- `op_addr` in 32: byte address.
- `op_wdata` in 32: store data.
- `op_rd` in 5: load destination register.
- `mem_req` out 1: memory request, held until ack or timeout.
- `mem_we` out 1: 1 = store.
- `mem_addr` out 32: `{op_addr[31:2],2'b00}`.
- `mem_be` out 4: byte enables.
- `mem_wdata` out 32: lane-replicated store data.
- `mem_ack` in 1: memory completion, one-cycle pulse.
- `mem_rdata` in 32: load word, valid with `mem_ack`.
- `rf_we` out 3: register-file write code; only 0 or 1 is ever driven.
- `rf_addr` out 5: destination register.
- `rf_data` out 32: extended load value.
- `done` out 1: one-cycle pulse when an operation completes.
- `err_access` out 1: one-cycle pulse for a misaligned access or illegal funct3.
- `err_timeout` out 1: one-cycle pulse on memory timeout.

## Operation
- States: IDLE, REQ, WB. All outputs are registered.
- Reset values: state IDLE; `op_ready`=1; all other outputs 0; timeout counter 0.
- IDLE, on accept:
  - Latch `op_load`, `op_funct3`, `addr[1:0]`, `op_rd`.
  - Illegal cases:
    - funct3 ∈ {011,110,111};
    - bu/hu on a store;
    - h/hu with `addr[0]`=1;
    - w with `addr[1:0]`≠0.
  - Illegal case: pulse `err_access` next cycle, stay IDLE, no memory access.
  - Otherwise go to REQ with `mem_req`=1 and `mem_addr`/`mem_we`/`mem_be`/`mem_wdata` driven from the registers.
- Store lanes:
  - b: `be` = 1<<addr[1:0]; `wdata` = {4{op_wdata[7:0]}}.
  - h: `be` = 0011 (addr[1]=0) or 1100 (addr[1]=1); `wdata` = {2{op_wdata[15:0]}}.
  - w: `be` = 1111; `wdata` = `op_wdata`.
- Loads drive `mem_be` = 1111.
- REQ:
  - `mem_ack` on a store: drop `mem_req`, pulse `done`, go to IDLE.
  - `mem_ack` on a load: capture the extracted value, go to WB.
  - Load extraction: byte = `rdata[8*a+7:8*a]`; half = `rdata[16*a1+15:16*a1]`. b/h sign-extend; bu/hu zero-extend; w is passed through.
  - Counter increments each REQ cycle without ack. On reaching `MEM_TIMEOUT`: drop `mem_req`, pulse `err_timeout`, go to IDLE, no register write.
- WB, one cycle:
  - `rf_we`=1 if rd≠0, else 0.
  - `rf_addr`=rd, `rf_data`=value, `done`=1.
  - Next state IDLE.
- Counter clears on entry to REQ.
- `mem_ack` is ignored outside REQ.
- `reset_n` low at any point: immediately returns to reset values and drops `mem_req` mid-transaction. A later stray `mem_ack` is ignored.

## Timing
- Accept at edge 0 → `mem_req` high after edge 0.
- `mem_ack` sampled at edge k → load: `rf_we`/`done` high for the cycle after edge k, `op_ready` high after edge k+1. Store: `done` high and `op_ready` high after edge k.
- Minimum latency, accept to register write visible: 2 cycles for a load with ack at the first REQ cycle.
- `mem_req`/`mem_addr`/`mem_be`/`mem_wdata` are stable for the entire REQ state.
- Throughput: one operation per (2 + wait) cycles for a store, (3 + wait) for a load; no overlap.
- Timeout: `mem_req` high for exactly `MEM_TIMEOUT` cycles, then `err_timeout` pulses.

## Test plan
- lb, addr 0x103, rd=5, `mem_rdata`=0x80FF_1234, ack at first REQ cycle → `rf_we`=1, `rf_addr`=5, `rf_data`=0xFFFF_FF80, `done` 2 cycles after accept.
- lhu, addr 0x202, rd=7, rdata 0xBEEF_0000 → `rf_data`=0x0000_BEEF. lh at the same address → 0xFFFF_BEEF.
- sb, addr 0x11, wdata 0x1234_56AB → `mem_be`=0010, `mem_wdata`=0xABAB_ABAB, `mem_addr`=0x10. Ack after 3 wait cycles → single `done`, no `rf_we`.
- lw, addr 0x6 → `err_access` pulse, `mem_req` never asserted, `op_ready` returns the next cycle. funct3=011 → same result.
- `MEM_TIMEOUT`=4, load with no ack → `mem_req` high 4 cycles, `err_timeout` pulse, `rf_we` stays 0. lw to rd=0 with ack → `rf_we`=0, `done`=1.
- `reset_n` low during REQ → `mem_req`=0 immediately, state IDLE. Ack arriving after release → no `done`, no `rf_we`.
